// File: rtl/mic_pkg.sv
// Shared defaults, derived frame constants and FSM state types for the I2S mic array sequencer.
package mic_pkg;

  localparam int unsigned BCLK_DIV      = 32;
  localparam int unsigned SLOT_BITS     = 32;
  localparam int unsigned SAMPLE_BITS   = 24;
  localparam int unsigned NUM_MICS      = 3;
  localparam int unsigned FRAME_BITS    = 2 * SLOT_BITS;
  localparam int unsigned CAPTURE_PHASE = BCLK_DIV / 2;

  typedef enum logic {F_OFF, F_RUN} frame_state_t;
  typedef enum logic {O_IDLE, O_EMIT} out_state_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// Frame engine: owns the BCLK divider and frame bit counter, drives BCLK/LRCL and
// flags the capture phase and frame boundary for the deserializer.
module i2s_clk_gen #(
  parameter int unsigned BCLK_DIV    = mic_pkg::BCLK_DIV,
  parameter int unsigned SLOT_BITS   = mic_pkg::SLOT_BITS,
  parameter int unsigned SAMPLE_BITS = mic_pkg::SAMPLE_BITS
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic enable,
  output logic busy,
  output logic i2s_clk,
  output logic lrcl_clk,
  output logic capture_strobe_c,
  output logic capture_last_c,
  output logic frame_end_c
);
  import mic_pkg::*;

  localparam int unsigned FRAME_LEN = 2 * SLOT_BITS;
  localparam int unsigned HALF_DIV  = BCLK_DIV / 2;
  localparam int unsigned DIV_W     = $clog2(BCLK_DIV);
  localparam int unsigned BIT_W     = $clog2(FRAME_LEN);

  frame_state_t     state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_nxt;
  logic             div_wrap;
  logic             at_capture;

  assign div_wrap         = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign at_capture       = (state == F_RUN) && (div_cnt == DIV_W'(HALF_DIV));
  assign capture_strobe_c = at_capture && (bit_cnt >= BIT_W'(1)) &&
                            (bit_cnt <= BIT_W'(SAMPLE_BITS));
  assign capture_last_c   = at_capture && (bit_cnt == BIT_W'(SAMPLE_BITS));
  assign frame_end_c      = (state == F_RUN) && div_wrap && (bit_cnt == BIT_W'(FRAME_LEN - 1));

  // Stop requests only take effect at a frame boundary so no partial frame is produced.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    case (state)
      F_OFF: begin
        div_nxt = '0;
        bit_nxt = '0;
        if (enable) state_nxt = F_RUN;
      end
      F_RUN: begin
        if (div_wrap) begin
          div_nxt = '0;
          if (frame_end_c) begin
            bit_nxt = '0;
            if (!enable) state_nxt = F_OFF;
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      default: state_nxt = F_OFF;
    endcase
  end

  // Clocks are registered from next-state counters so they line up with div_cnt/bit_cnt.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= F_OFF;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      i2s_clk  <= 1'b0;
      lrcl_clk <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      bit_cnt  <= bit_nxt;
      busy     <= (state_nxt == F_RUN);
      i2s_clk  <= (state_nxt == F_RUN) && (div_nxt >= DIV_W'(HALF_DIV));
      lrcl_clk <= (state_nxt == F_RUN) && (bit_nxt >= BIT_W'(SLOT_BITS));
    end
  end

endmodule

// File: rtl/mic_array_sequencer.sv
// Shared-clock I2S mic array master: deserializes all left-slot samples in lockstep
// and streams them out one mic at a time over a valid/ready handshake.
module mic_array_sequencer #(
  parameter int unsigned BCLK_DIV    = mic_pkg::BCLK_DIV,
  parameter int unsigned SLOT_BITS   = mic_pkg::SLOT_BITS,
  parameter int unsigned SAMPLE_BITS = mic_pkg::SAMPLE_BITS,
  parameter int unsigned NUM_MICS    = mic_pkg::NUM_MICS
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   enable_in,
  input  logic [NUM_MICS-1:0]    mic_data_in,
  output logic                   i2s_clk_out,
  output logic                   lrcl_clk_out,
  output logic [SAMPLE_BITS-1:0] sample_out,
  output logic [1:0]             mic_id_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic                   overrun_out,
  input  logic                   clear_overrun_in,
  output logic                   busy_out
);
  import mic_pkg::*;

  logic                   capture_strobe_c;
  logic                   capture_last_c;
  logic                   frame_end_c;
  logic                   frame_done_q;
  logic [SAMPLE_BITS-1:0] shreg [NUM_MICS];
  logic [SAMPLE_BITS-1:0] hold  [NUM_MICS];
  out_state_t             out_state;
  logic [1:0]             idx;
  logic [1:0]             next_idx;

  i2s_clk_gen #(
    .BCLK_DIV   (BCLK_DIV),
    .SLOT_BITS  (SLOT_BITS),
    .SAMPLE_BITS(SAMPLE_BITS)
  ) u_clk_gen (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .enable          (enable_in),
    .busy            (busy_out),
    .i2s_clk         (i2s_clk_out),
    .lrcl_clk        (lrcl_clk_out),
    .capture_strobe_c(capture_strobe_c),
    .capture_last_c  (capture_last_c),
    .frame_end_c     (frame_end_c)
  );

  // One MSB-first shift register per mic, cleared at each frame boundary.
  for (genvar g = 0; g < int'(NUM_MICS); g++) begin : g_shift
    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        shreg[g] <= '0;
      end else if (capture_strobe_c) begin
        shreg[g] <= {shreg[g][SAMPLE_BITS-2:0], mic_data_in[g]};
      end else if (frame_end_c) begin
        shreg[g] <= '0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) frame_done_q <= 1'b0;
    else         frame_done_q <= capture_last_c;
  end

  assign next_idx = idx + 2'd1;

  // A new frame always restarts emission at mic 0, dropping any undrained remainder.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      out_state  <= O_IDLE;
      idx        <= '0;
      valid_out  <= 1'b0;
      sample_out <= '0;
      mic_id_out <= '0;
      hold       <= '{default: '0};
    end else if (frame_done_q) begin
      out_state  <= O_EMIT;
      hold       <= shreg;
      idx        <= '0;
      valid_out  <= 1'b1;
      sample_out <= shreg[0];
      mic_id_out <= '0;
    end else if (out_state == O_EMIT && ready_in) begin
      if (idx == 2'(NUM_MICS - 1)) begin
        out_state <= O_IDLE;
        valid_out <= 1'b0;
      end else begin
        idx        <= next_idx;
        sample_out <= hold[next_idx];
        mic_id_out <= next_idx;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                                      overrun_out <= 1'b0;
    else if (clear_overrun_in)                        overrun_out <= 1'b0;
    else if (frame_done_q && out_state == O_EMIT)     overrun_out <= 1'b1;
  end

endmodule
